// File: rtl/memory_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter_if
// Brief    : Requester channels (ifetch, dload, dstore) and external bus.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_port_arbiter_if;
    logic        ifetch_request_i;
    logic [31:0] ifetch_address_i;
    logic [31:0] ifetch_data_o;
    logic        ifetch_valid_o;
    logic        dload_request_i;
    logic [31:0] dload_address_i;
    logic [31:0] dload_data_o;
    logic        dload_valid_o;
    logic        dstore_request_i;
    logic [31:0] dstore_address_i;
    logic [31:0] dstore_data_i;
    logic [1:0]  dstore_width_i;
    logic        dstore_done_o;
    logic        bus_request_o;
    logic        bus_write_o;
    logic [31:0] bus_address_o;
    logic [31:0] bus_wdata_o;
    logic [1:0]  bus_width_o;
    logic [31:0] bus_rdata_i;
    logic        bus_valid_i;
    logic        bus_done_i;

    modport slave (
        input  ifetch_request_i, ifetch_address_i, dload_request_i, dload_address_i,
               dstore_request_i, dstore_address_i, dstore_data_i, dstore_width_i,
               bus_rdata_i, bus_valid_i, bus_done_i,
        output ifetch_data_o, ifetch_valid_o, dload_data_o, dload_valid_o, dstore_done_o,
               bus_request_o, bus_write_o, bus_address_o, bus_wdata_o, bus_width_o
    );

    modport master (
        output ifetch_request_i, ifetch_address_i, dload_request_i, dload_address_i,
               dstore_request_i, dstore_address_i, dstore_data_i, dstore_width_i,
               bus_rdata_i, bus_valid_i, bus_done_i,
        input  ifetch_data_o, ifetch_valid_o, dload_data_o, dload_valid_o, dstore_done_o,
               bus_request_o, bus_write_o, bus_address_o, bus_wdata_o, bus_width_o
    );
endinterface
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter
// Brief    : Three-master single-outstanding memory port arbiter with
//            starvation promotion for the two load channels.
// Revision : 1.0 - initial release
// ============================================================================
module memory_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input wire                    clk_i,
    input wire                    rst_n_i,
    memory_port_arbiter_if.slave  port_if
);
    localparam int          CW       = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [1:0] G_NONE   = 2'd0;
    localparam logic [1:0] G_STORE  = 2'd1;
    localparam logic [1:0] G_DLOAD  = 2'd2;
    localparam logic [1:0] G_IFETCH = 2'd3;

    localparam logic [1:0] C_WORD   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [1:0]    r_grant;
    logic [1:0]    w_winner;
    logic [CW-1:0] r_ifetch_lost;
    logic [CW-1:0] r_dload_lost;
    logic          r_bus_write;
    logic [31:0]   r_bus_address;
    logic [31:0]   r_bus_wdata;
    logic [1:0]    r_bus_width;
    logic          w_busy;
    logic          w_resp;
    logic          w_ifetch_valid;
    logic          w_dload_valid;

    // Starved loads outrank the store; dload wins a tie between starved loads.
    always_comb begin
        if (port_if.dload_request_i && (r_dload_lost == C_LIMIT))
            w_winner = G_DLOAD;
        else if (port_if.ifetch_request_i && (r_ifetch_lost == C_LIMIT))
            w_winner = G_IFETCH;
        else if (port_if.dstore_request_i)
            w_winner = G_STORE;
        else if (port_if.dload_request_i)
            w_winner = G_DLOAD;
        else if (port_if.ifetch_request_i)
            w_winner = G_IFETCH;
        else
            w_winner = G_NONE;
    end

    always_comb begin
        w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT);
        w_resp = w_busy &&
                 (((r_grant == G_STORE) && port_if.bus_done_i) ||
                  (((r_grant == G_DLOAD) || (r_grant == G_IFETCH)) && port_if.bus_valid_i));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = (w_winner != G_NONE) ? S_ISSUE : S_IDLE;
            S_ISSUE: w_state_next = w_resp ? S_IDLE : S_WAIT;
            S_WAIT:  w_state_next = w_resp ? S_IDLE : S_WAIT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bus operands are captured only at arbitration, so requester changes
    // during a transaction cannot disturb it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_grant       <= G_NONE;
            r_ifetch_lost <= '0;
            r_dload_lost  <= '0;
            r_bus_write   <= 1'b0;
            r_bus_address <= '0;
            r_bus_wdata   <= '0;
            r_bus_width   <= '0;
        end else if (r_state == S_IDLE) begin
            r_grant <= w_winner;
            if (w_winner != G_NONE) begin
                case (w_winner)
                    G_STORE: begin
                        r_bus_write   <= 1'b1;
                        r_bus_address <= port_if.dstore_address_i;
                        r_bus_wdata   <= port_if.dstore_data_i;
                        r_bus_width   <= port_if.dstore_width_i;
                    end
                    G_DLOAD: begin
                        r_bus_write   <= 1'b0;
                        r_bus_address <= port_if.dload_address_i;
                        r_bus_wdata   <= '0;
                        r_bus_width   <= C_WORD;
                    end
                    default: begin
                        r_bus_write   <= 1'b0;
                        r_bus_address <= port_if.ifetch_address_i;
                        r_bus_wdata   <= '0;
                        r_bus_width   <= C_WORD;
                    end
                endcase

                if (w_winner == G_IFETCH)
                    r_ifetch_lost <= '0;
                else if (port_if.ifetch_request_i && (r_ifetch_lost != C_LIMIT))
                    r_ifetch_lost <= r_ifetch_lost + CW'(1);

                if (w_winner == G_DLOAD)
                    r_dload_lost <= '0;
                else if (port_if.dload_request_i && (r_dload_lost != C_LIMIT))
                    r_dload_lost <= r_dload_lost + CW'(1);
            end
        end else if (w_resp) begin
            r_grant <= G_NONE;
        end
    end

    always_comb begin
        w_ifetch_valid         = w_resp && (r_grant == G_IFETCH);
        w_dload_valid          = w_resp && (r_grant == G_DLOAD);
        port_if.ifetch_valid_o = w_ifetch_valid;
        port_if.dload_valid_o  = w_dload_valid;
        port_if.dstore_done_o  = w_resp && (r_grant == G_STORE);
        port_if.ifetch_data_o  = w_ifetch_valid ? port_if.bus_rdata_i : 32'd0;
        port_if.dload_data_o   = w_dload_valid  ? port_if.bus_rdata_i : 32'd0;
        port_if.bus_request_o  = (r_state == S_ISSUE);
        port_if.bus_write_o    = r_bus_write;
        port_if.bus_address_o  = r_bus_address;
        port_if.bus_wdata_o    = r_bus_wdata;
        port_if.bus_width_o    = r_bus_width;
    end
endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_memory_port_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            checked against a transaction-level arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic clk_i = 1'b0;
    logic rst_n_i;
    int   checks;
    int   passed;

    memory_port_arbiter_if bus_if();

    memory_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .port_if (bus_if.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [134:0] outs();
        return {bus_if.bus_request_o, bus_if.bus_write_o, bus_if.bus_address_o,
                bus_if.bus_wdata_o, bus_if.bus_width_o, bus_if.ifetch_valid_o,
                bus_if.ifetch_data_o, bus_if.dload_valid_o, bus_if.dload_data_o,
                bus_if.dstore_done_o};
    endfunction

    function automatic logic [2:0] pulses_now();
        return {bus_if.dstore_done_o, bus_if.dload_valid_o, bus_if.ifetch_valid_o};
    endfunction

    // Bus-side responder: waits for one bus_request_o, answers after 'delay'
    // cycles, and reports what the master side saw. Leaves time at #1 after
    // the edge that returns the arbiter to IDLE.
    task automatic serve_one(input int delay, input bit wrong_first, input logic [31:0] rdata,
                             output bit seen, output int wait_cycles, output logic wr,
                             output logic [31:0] addr, output logic [1:0] width,
                             output logic [31:0] wdata, output logic [2:0] pulses,
                             output logic [31:0] idata, output logic [31:0] ddata,
                             output bit steady);
        logic [31:0] sv_ia, sv_da, sv_sa, sv_sd;
        logic [1:0]  sv_sw;
        seen = 1'b0; wait_cycles = 0; steady = 1'b1; pulses = '0;
        idata = '0; ddata = '0; wr = 1'b0; addr = '0; width = '0; wdata = '0;
        for (int c = 0; c < 40; c++) begin
            if (bus_if.bus_request_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            wait_cycles++;
        end
        if (!seen) return;
        wr = bus_if.bus_write_o; addr = bus_if.bus_address_o;
        width = bus_if.bus_width_o; wdata = bus_if.bus_wdata_o;
        sv_ia = bus_if.ifetch_address_i; sv_da = bus_if.dload_address_i;
        sv_sa = bus_if.dstore_address_i; sv_sd = bus_if.dstore_data_i;
        sv_sw = bus_if.dstore_width_i;
        for (int d = 0; d <= delay; d++) begin
            if (d > 0) begin
                @(posedge clk_i); #1;
                bus_if.bus_valid_i = 1'b0;
                bus_if.bus_done_i  = 1'b0;
                bus_if.ifetch_address_i = $urandom;
                bus_if.dload_address_i  = $urandom;
                bus_if.dstore_address_i = $urandom;
                bus_if.dstore_data_i    = $urandom;
                bus_if.dstore_width_i   = 2'($urandom_range(0, 2));
                if (bus_if.bus_request_o !== 1'b0 || bus_if.bus_write_o !== wr ||
                    bus_if.bus_address_o !== addr || bus_if.bus_width_o !== width ||
                    bus_if.bus_wdata_o !== wdata)
                    steady = 1'b0;
            end
            if (d < delay) begin
                if (wrong_first && d == 1) begin
                    bus_if.bus_rdata_i = $urandom;
                    if (wr) bus_if.bus_valid_i = 1'b1;
                    else    bus_if.bus_done_i  = 1'b1;
                end
                #1;
                if (pulses_now() !== 3'b000 || bus_if.ifetch_data_o !== 32'd0 ||
                    bus_if.dload_data_o !== 32'd0)
                    steady = 1'b0;
            end else begin
                bus_if.bus_rdata_i = rdata;
                if (wr) bus_if.bus_done_i  = 1'b1;
                else    bus_if.bus_valid_i = 1'b1;
                #1;
                pulses = pulses_now();
                idata  = bus_if.ifetch_data_o;
                ddata  = bus_if.dload_data_o;
            end
        end
        @(posedge clk_i); #1;
        bus_if.bus_valid_i = 1'b0;
        bus_if.bus_done_i  = 1'b0;
        bus_if.ifetch_address_i = sv_ia; bus_if.dload_address_i = sv_da;
        bus_if.dstore_address_i = sv_sa; bus_if.dstore_data_i = sv_sd;
        bus_if.dstore_width_i   = sv_sw;
    endtask

    task automatic test_reset();
        bus_if.ifetch_request_i = 0; bus_if.ifetch_address_i = 0;
        bus_if.dload_request_i  = 0; bus_if.dload_address_i  = 0;
        bus_if.dstore_request_i = 0; bus_if.dstore_address_i = 0;
        bus_if.dstore_data_i    = 0; bus_if.dstore_width_i   = 0;
        bus_if.bus_rdata_i = 32'h5A5A_A5A5; bus_if.bus_valid_i = 1; bus_if.bus_done_i = 1;
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (outs() !== '0) $display("FAIL reset_outputs: got %h expected 0", outs());
        else passed++;
        bus_if.bus_valid_i = 0; bus_if.bus_done_i = 0;
        @(negedge clk_i); rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (outs() !== '0) $display("FAIL idle_no_request: got %h expected 0", outs());
        else passed++;
    endtask

    task automatic test_simultaneous();
        bit seen, steady; int wc;
        logic wr; logic [31:0] addr, wdata, idata, ddata; logic [1:0] width; logic [2:0] pulses;
        logic [31:0] exp_addr; logic [2:0] exp_p;
        bus_if.ifetch_address_i = 32'hA000_0000; bus_if.dload_address_i = 32'hB000_0000;
        bus_if.dstore_address_i = 32'hC000_0000; bus_if.dstore_data_i = 32'h1234_5678;
        bus_if.dstore_width_i = 2'd2;
        bus_if.ifetch_request_i = 1; bus_if.dload_request_i = 1; bus_if.dstore_request_i = 1;
        for (int k = 0; k < 3; k++) begin
            serve_one(2, 1'b0, 32'h0BAD_0000 + k, seen, wc, wr, addr, width, wdata,
                      pulses, idata, ddata, steady);
            exp_addr = (k == 0) ? 32'hC000_0000 : (k == 1) ? 32'hB000_0000 : 32'hA000_0000;
            exp_p    = (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
            checks++;
            if (!seen || wc != 1)
                $display("FAIL simul_issue_latency[%0d]: got seen=%0d cycles=%0d expected 1 1", k, seen, wc);
            else passed++;
            checks++;
            if (addr !== exp_addr || pulses !== exp_p || !steady)
                $display("FAIL simul_order[%0d]: got addr=%h pulses=%b steady=%0d expected %h %b 1",
                         k, addr, pulses, steady, exp_addr, exp_p);
            else passed++;
            if (k == 0) bus_if.dstore_request_i = 0;
            if (k == 1) bus_if.dload_request_i = 0;
            if (k == 2) bus_if.ifetch_request_i = 0;
        end
    endtask

    task automatic test_dload_read();
        bit seen, steady; int wc;
        logic wr; logic [31:0] addr, wdata, idata, ddata; logic [1:0] width; logic [2:0] pulses;
        bus_if.dload_address_i = 32'h0000_1000; bus_if.dload_request_i = 1;
        serve_one(1, 1'b0, 32'hDEAD_BEEF, seen, wc, wr, addr, width, wdata, pulses, idata, ddata, steady);
        bus_if.dload_request_i = 0;
        checks++;
        if (wr !== 1'b0 || addr !== 32'h0000_1000 || width !== 2'd2)
            $display("FAIL dload_bus_fields: got wr=%b addr=%h width=%0d expected 0 00001000 2", wr, addr, width);
        else passed++;
        checks++;
        if (pulses !== 3'b010 || ddata !== 32'hDEAD_BEEF || idata !== 32'd0)
            $display("FAIL dload_response: got pulses=%b ddata=%h idata=%h expected 010 deadbeef 0",
                     pulses, ddata, idata);
        else passed++;
    endtask

    task automatic test_wrong_response();
        bit seen, steady; int wc;
        logic wr; logic [31:0] addr, wdata, idata, ddata; logic [1:0] width; logic [2:0] pulses;
        bus_if.dstore_address_i = 32'h0000_2220; bus_if.dstore_data_i = 32'h7777_1111;
        bus_if.dstore_width_i = 2'd2; bus_if.dstore_request_i = 1;
        serve_one(3, 1'b1, 32'd0, seen, wc, wr, addr, width, wdata, pulses, idata, ddata, steady);
        bus_if.dstore_request_i = 0;
        checks++;
        if (!steady) $display("FAIL wrong_kind_ignored: got steady=0 expected 1");
        else passed++;
        checks++;
        if (pulses !== 3'b100 || wr !== 1'b1)
            $display("FAIL store_done_after_wrong: got pulses=%b wr=%b expected 100 1", pulses, wr);
        else passed++;
    endtask

    task automatic test_byte_store();
        bit seen, steady; int wc;
        logic wr; logic [31:0] addr, wdata, idata, ddata; logic [1:0] width; logic [2:0] pulses;
        bus_if.dstore_address_i = 32'h0000_0003; bus_if.dstore_data_i = 32'h0000_00AB;
        bus_if.dstore_width_i = 2'd0; bus_if.dstore_request_i = 1;
        serve_one(3, 1'b0, 32'd0, seen, wc, wr, addr, width, wdata, pulses, idata, ddata, steady);
        bus_if.dstore_request_i = 0;
        checks++;
        if (wr !== 1'b1 || width !== 2'd0 || addr !== 32'h0000_0003 || wdata !== 32'h0000_00AB)
            $display("FAIL byte_store_fields: got wr=%b width=%0d addr=%h wdata=%h expected 1 0 00000003 000000ab",
                     wr, width, addr, wdata);
        else passed++;
        checks++;
        if (!steady || pulses !== 3'b100)
            $display("FAIL byte_store_stable: got steady=%0d pulses=%b expected 1 100", steady, pulses);
        else passed++;
    endtask

    task automatic test_starvation();
        bit seen, steady; int wc;
        logic wr; logic [31:0] addr, wdata, idata, ddata; logic [1:0] width; logic [2:0] pulses;
        logic [2:0] exp_p;
        bus_if.dstore_address_i = 32'h0000_4000; bus_if.dstore_data_i = 32'h1;
        bus_if.dstore_width_i = 2'd2; bus_if.ifetch_address_i = 32'h0000_2000;
        bus_if.dstore_request_i = 1; bus_if.ifetch_request_i = 1;
        for (int a = 1; a <= STARVE_LIMIT + 1; a++) begin
            serve_one(1, 1'b0, 32'h600D_0000 + a, seen, wc, wr, addr, width, wdata,
                      pulses, idata, ddata, steady);
            exp_p = (a <= STARVE_LIMIT) ? 3'b100 : 3'b001;
            checks++;
            if (pulses !== exp_p || !seen)
                $display("FAIL starve_arb[%0d]: got pulses=%b expected %b", a, pulses, exp_p);
            else passed++;
        end
        checks++;
        if (addr !== 32'h0000_2000 || idata !== 32'h600D_0000 + STARVE_LIMIT + 1)
            $display("FAIL starve_ifetch_data: got addr=%h data=%h expected 00002000 %h",
                     addr, idata, 32'h600D_0000 + STARVE_LIMIT + 1);
        else passed++;
        bus_if.dstore_request_i = 0; bus_if.ifetch_request_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (bus_if.bus_request_o !== 1'b0)
            $display("FAIL idle_after_drain: got %b expected 0", bus_if.bus_request_o);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        bit seen, steady; int wc;
        logic wr; logic [31:0] addr, wdata, idata, ddata; logic [1:0] width; logic [2:0] pulses;
        seen = 1'b0;
        bus_if.ifetch_address_i = 32'h0000_3000; bus_if.ifetch_request_i = 1;
        for (int c = 0; c < 10; c++) begin
            if (bus_if.bus_request_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        bus_if.bus_rdata_i = 32'hCAFE_F00D; bus_if.bus_valid_i = 1; #1;
        checks++;
        if (!seen || bus_if.ifetch_valid_o !== 1'b1)
            $display("FAIL wait_response: got seen=%0d valid=%b expected 1 1", seen, bus_if.ifetch_valid_o);
        else passed++;
        rst_n_i = 1'b0; #1;
        checks++;
        if (outs() !== '0) $display("FAIL async_reset_outputs: got %h expected 0", outs());
        else passed++;
        bus_if.bus_valid_i = 0;
        @(negedge clk_i); rst_n_i = 1'b1; #1;
        checks++;
        if (bus_if.bus_request_o !== 1'b0)
            $display("FAIL post_reset_idle: got %b expected 0", bus_if.bus_request_o);
        else passed++;
        @(posedge clk_i); #1;
        checks++;
        if (bus_if.bus_request_o !== 1'b1 || bus_if.bus_address_o !== 32'h0000_3000)
            $display("FAIL post_reset_issue: got req=%b addr=%h expected 1 00003000",
                     bus_if.bus_request_o, bus_if.bus_address_o);
        else passed++;
        serve_one(1, 1'b0, 32'h1357_9BDF, seen, wc, wr, addr, width, wdata, pulses, idata, ddata, steady);
        bus_if.ifetch_request_i = 0;
        checks++;
        if (pulses !== 3'b001 || idata !== 32'h1357_9BDF)
            $display("FAIL post_reset_complete: got pulses=%b data=%h expected 001 13579bdf", pulses, idata);
        else passed++;
    endtask

    task automatic test_random();
        bit seen, steady, wrong; int wc, delay, win;
        logic wr; logic [31:0] addr, wdata, idata, ddata, rd; logic [1:0] width; logic [2:0] pulses;
        bit p_s, p_d, p_i;
        int lost_d, lost_i;
        logic [31:0] m_sa, m_sd, m_da, m_ia; logic [1:0] m_sw;
        logic [31:0] e_addr; logic [2:0] e_p; logic e_wr; logic [1:0] e_w;
        p_s = 0; p_d = 0; p_i = 0; lost_d = 0; lost_i = 0;
        for (int it = 0; it < 80; it++) begin
            if (!p_s && $urandom_range(0, 1) == 1) begin
                p_s = 1; m_sa = $urandom; m_sd = $urandom; m_sw = 2'($urandom_range(0, 2));
            end
            if (!p_d && $urandom_range(0, 2) == 0) begin p_d = 1; m_da = $urandom; end
            if (!p_i && $urandom_range(0, 2) == 0) begin p_i = 1; m_ia = $urandom; end
            if (!p_s && !p_d && !p_i) begin p_i = 1; m_ia = $urandom; end
            bus_if.dstore_request_i = p_s; bus_if.dload_request_i = p_d; bus_if.ifetch_request_i = p_i;
            if (p_s) begin
                bus_if.dstore_address_i = m_sa; bus_if.dstore_data_i = m_sd; bus_if.dstore_width_i = m_sw;
            end
            if (p_d) bus_if.dload_address_i = m_da;
            if (p_i) bus_if.ifetch_address_i = m_ia;

            if (p_d && lost_d == STARVE_LIMIT)      win = 2;
            else if (p_i && lost_i == STARVE_LIMIT) win = 3;
            else if (p_s)                           win = 1;
            else if (p_d)                           win = 2;
            else                                    win = 3;
            if (win == 2) lost_d = 0; else if (p_d) lost_d = (lost_d + 1 > STARVE_LIMIT) ? STARVE_LIMIT : lost_d + 1;
            if (win == 3) lost_i = 0; else if (p_i) lost_i = (lost_i + 1 > STARVE_LIMIT) ? STARVE_LIMIT : lost_i + 1;
            e_addr = (win == 1) ? m_sa : (win == 2) ? m_da : m_ia;
            e_p    = (win == 1) ? 3'b100 : (win == 2) ? 3'b010 : 3'b001;
            e_wr   = (win == 1);
            e_w    = (win == 1) ? m_sw : 2'd2;

            delay = $urandom_range(0, 3);
            wrong = (delay >= 2) && ($urandom_range(0, 1) == 1);
            rd    = $urandom;
            serve_one(delay, wrong, rd, seen, wc, wr, addr, width, wdata, pulses, idata, ddata, steady);

            checks++;
            if (!seen || wc != 1)
                $display("FAIL rnd_latency[%0d]: got seen=%0d cycles=%0d expected 1 1", it, seen, wc);
            else passed++;
            checks++;
            if (pulses !== e_p || addr !== e_addr)
                $display("FAIL rnd_grant[%0d]: got pulses=%b addr=%h expected %b %h", it, pulses, addr, e_p, e_addr);
            else passed++;
            checks++;
            if (wr !== e_wr || width !== e_w || (e_wr && wdata !== m_sd))
                $display("FAIL rnd_fields[%0d]: got wr=%b w=%0d wdata=%h expected %b %0d %h",
                         it, wr, width, wdata, e_wr, e_w, m_sd);
            else passed++;
            checks++;
            if (idata !== ((win == 3) ? rd : 32'd0) || ddata !== ((win == 2) ? rd : 32'd0) || !steady)
                $display("FAIL rnd_data[%0d]: got i=%h d=%h steady=%0d expected rd=%h to master %0d",
                         it, idata, ddata, steady, rd, win);
            else passed++;

            if (win == 1) begin p_s = 0; bus_if.dstore_request_i = 0; end
            if (win == 2) begin p_d = 0; bus_if.dload_request_i = 0; end
            if (win == 3) begin p_i = 0; bus_if.ifetch_request_i = 0; end
        end
        bus_if.dstore_request_i = 0; bus_if.dload_request_i = 0; bus_if.ifetch_request_i = 0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_simultaneous();
        test_dload_read();
        test_wrong_response();
        test_byte_store();
        test_starvation();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
